uart_tx_arbiter: RTL and testbench

- Shares one 8N2 async UART transmitter between NUM_REQ byte-stream requesters.
- Grants are packet-atomic and round-robin: once a requester is granted, all its bytes up to and including the one flagged last go out back-to-back before another requester is served.
- Sits between the acquisition/status producers and the transmitter's TxD_start/TxD_data/TxD_busy interface.
- Paces every byte off the transmitter's busy handshake.

---
 rtl/uart_tx_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one 8N2 UART transmitter between NUM_REQ streams.
// Optional: define UART_ARB_HEADER_EN to prefix each packet with {4'hA, 1'b0, grant_id}.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned GAP_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 tx_start_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_busy_i,
    output logic [ID_W-1:0]      grant_id_o,
    output logic                 grant_active_o,
    output logic                 abort_pulse_o
);

    localparam int unsigned GapW = $clog2(GAP_TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWaitHi,
        StWaitLo
`ifdef UART_ARB_HEADER_EN
        , StHdr
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     gid_q, gid_d;
    logic                active_q, active_d;
    logic [GapW-1:0]     gap_q, gap_d;
    logic                last_q, last_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]  ready_q, ready_d;
    logic                abort_q, abort_d;

    logic                win_found;
    logic [ID_W-1:0]     win_id;
    int unsigned         cand;
    logic                gnt_valid;
    logic                gap_expire;

    assign gnt_valid  = req_valid_i[gid_q];
    assign gap_expire = (gap_q == GapW'(GAP_TIMEOUT - 1));

`ifdef UART_ARB_HEADER_EN
    logic [2:0] hdr_id;
    assign hdr_id = 3'(gid_q);
`endif

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = 32'(ptr_q) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!win_found && req_valid_i[ID_W'(cand)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            gid_q      <= '0;
            active_q   <= 1'b0;
            gap_q      <= '0;
            last_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            ready_q    <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gid_q      <= gid_d;
            active_q   <= active_d;
            gap_q      <= gap_d;
            last_q     <= last_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            ready_q    <= ready_d;
            abort_q    <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
`ifdef UART_ARB_HEADER_EN
                if (win_found) state_d = StHdr;
`else
                if (win_found) state_d = StSend;
`endif
            end
`ifdef UART_ARB_HEADER_EN
            StHdr:    if (!tx_busy_i) state_d = StWaitHi;
`endif
            StSend: begin
                if (gnt_valid) begin
                    if (!tx_busy_i) state_d = StWaitHi;
                end else if (gap_expire) begin
                    state_d = StIdle;
                end
            end
            StWaitHi: if (tx_busy_i) state_d = StWaitLo;
            StWaitLo: if (!tx_busy_i) state_d = last_q ? StIdle : StSend;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        ptr_d      = ptr_q;
        gid_d      = gid_q;
        active_d   = active_q;
        gap_d      = gap_q;
        last_d     = last_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        ready_d    = '0;
        abort_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    gid_d    = win_id;
                    active_d = 1'b1;
                    gap_d    = '0;
                    ptr_d    = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
                end
            end
`ifdef UART_ARB_HEADER_EN
            StHdr: begin
                if (!tx_busy_i) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = {4'hA, 1'b0, hdr_id};
                    last_d     = 1'b0;
                end
            end
`endif
            StSend: begin
                if (gnt_valid) begin
                    if (!tx_busy_i) begin
                        tx_start_d = 1'b1;
                        ready_d    = NUM_REQ'(1) << gid_q;
                        tx_data_d  = req_data_i[8*gid_q +: 8];
                        last_d     = req_last_i[gid_q];
                        gap_d      = '0;
                    end
                end else if (gap_expire) begin
                    abort_d  = 1'b1;
                    active_d = 1'b0;
                    gap_d    = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StWaitLo: if (!tx_busy_i && last_q) active_d = 1'b0;
            default: ;
        endcase
    end

    assign req_ready_o    = ready_q;
    assign tx_start_o     = tx_start_q;
    assign tx_data_o      = tx_data_q;
    assign grant_id_o     = gid_q;
    assign grant_active_o = active_q;
    assign abort_pulse_o  = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a queue-level round-robin model predicts every
// transmitted byte; directed sequences cover reset, gap timeout and reset mid-frame.
module tb_uart_tx_arbiter;

    localparam int NUM   = 4;
    localparam int IDW   = 2;
    localparam int GAP   = 16;
    localparam int FRAME = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NUM-1:0]   req_valid = '0;
    logic [8*NUM-1:0] req_data = '0;
    logic [NUM-1:0]   req_last = '0;
    logic [NUM-1:0]   req_ready;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_busy = 1'b0;
    logic [IDW-1:0]   grant_id;
    logic             grant_active;
    logic             abort_pulse;
    int               busy_cnt = 0;

    uart_tx_arbiter #(
        .NUM_REQ    (NUM),
        .ID_W       (IDW),
        .GAP_TIMEOUT(GAP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_data_i    (req_data),
        .req_last_i    (req_last),
        .req_ready_o   (req_ready),
        .tx_start_o    (tx_start),
        .tx_data_o     (tx_data),
        .tx_busy_i     (tx_busy),
        .grant_id_o    (grant_id),
        .grant_active_o(grant_active),
        .abort_pulse_o (abort_pulse)
    );

    always #5 clk = ~clk;

    // Transmitter stand-in: no reset, busy for FRAME cycles after it latches a start.
    always @(posedge clk) begin
        if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) tx_busy <= 1'b0;
        end else if (tx_start) begin
            tx_busy  <= 1'b1;
            busy_cnt <= FRAME;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] q_byte [NUM][$];
    bit         q_last [NUM][$];
    logic [7:0] exp_data [$];
    int         exp_req [$];
    int         exp_gid [$];
    int         mdl_ptr = 0;

    task automatic push_byte(input int r, input logic [7:0] b, input bit l);
        q_byte[r].push_back(b);
        q_last[r].push_back(l);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NUM; i++) begin
            if (q_byte[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = q_byte[i][0];
                req_last[i]        = q_last[i][0];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NUM; i++) if (q_byte[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    // Whole packets in round-robin order over the requesters that still hold data.
    task automatic build_model();
        logic [7:0] cb [NUM][$];
        bit         cl [NUM][$];
        int         w;
        bit         l;
        exp_data.delete();
        exp_req.delete();
        exp_gid.delete();
        for (int i = 0; i < NUM; i++) begin
            cb[i] = q_byte[i];
            cl[i] = q_last[i];
        end
        while (1) begin
            w = -1;
            for (int off = 0; off < NUM; off++)
                if (w < 0 && cb[(mdl_ptr + off) % NUM].size() > 0) w = (mdl_ptr + off) % NUM;
            if (w < 0) break;
            mdl_ptr = (w + 1) % NUM;
`ifdef UART_ARB_HEADER_EN
            exp_data.push_back(8'hA0 | 8'(w));
            exp_req.push_back(-1);
            exp_gid.push_back(w);
`endif
            do begin
                exp_data.push_back(cb[w].pop_front());
                l = cl[w].pop_front();
                exp_req.push_back(w);
                exp_gid.push_back(w);
            end while (!l && cb[w].size() > 0);
        end
    endtask

    task automatic run_queues(input string tag);
        int         want [NUM];
        int         pulses [NUM];
        logic [7:0] ed;
        int         er, eg;
        build_model();
        for (int i = 0; i < NUM; i++) begin
            want[i]   = q_byte[i].size();
            pulses[i] = 0;
        end
        drive_reqs();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (tx_start) begin
                if (exp_data.size() == 0) begin
                    check_eq({tag, "_extra_start"}, 32'(tx_start), 32'd0);
                end else begin
                    ed = exp_data.pop_front();
                    er = exp_req.pop_front();
                    eg = exp_gid.pop_front();
                    check_eq({tag, "_tx_data"}, 32'(tx_data), 32'(ed));
                    check_eq({tag, "_grant_id"}, 32'(grant_id), 32'(eg));
                    check_eq({tag, "_ready"}, 32'(req_ready),
                             (er < 0) ? 32'd0 : (32'd1 << er));
                    check_eq({tag, "_start_busy"}, 32'(tx_busy), 32'd0);
                end
            end else if (req_ready != '0) begin
                check_eq({tag, "_ready_no_start"}, 32'(req_ready), 32'd0);
            end
            if (abort_pulse) check_eq({tag, "_abort"}, 32'(abort_pulse), 32'd0);
            for (int i = 0; i < NUM; i++) begin
                if (req_ready[i]) begin
                    pulses[i]++;
                    if (q_byte[i].size() > 0) begin
                        void'(q_byte[i].pop_front());
                        void'(q_last[i].pop_front());
                    end
                end
            end
            drive_reqs();
            if (exp_data.size() == 0 && all_empty() && !grant_active && !tx_busy && !tx_start)
                break;
        end
        check_eq({tag, "_bytes_left"}, 32'(exp_data.size()), 32'd0);
        check_eq({tag, "_active_end"}, 32'(grant_active), 32'd0);
        for (int i = 0; i < NUM; i++)
            check_eq({tag, "_pulses"}, 32'(pulses[i]), 32'(want[i]));
    endtask

    task automatic wait_tx_idle();
        int k = 0;
        while (tx_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("tx_idle", 32'(tx_busy), 32'd0);
    endtask

    task automatic do_reset();
        wait_tx_idle();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NUM; i++) begin
            q_byte[i].delete();
            q_last[i].delete();
        end
        drive_reqs();
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        mdl_ptr = 0;
    endtask

    task automatic wait_ready(input int r, input string tag);
        int k = 0;
        while (!req_ready[r] && k < 400) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_ready"}, 32'(req_ready[r]), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;
        int viol;

        repeat (3) @(negedge clk);
        check_eq("rst_tx_start", 32'(tx_start), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_grant_id", 32'(grant_id), 32'd0);
        check_eq("rst_active", 32'(grant_active), 32'd0);
        check_eq("rst_abort", 32'(abort_pulse), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("idle_active", 32'(grant_active), 32'd0);

        push_byte(1, 8'h55, 1'b0);
        push_byte(1, 8'hAA, 1'b1);
        run_queues("single");

        do_reset();
        push_byte(0, 8'h10, 1'b1);
        push_byte(0, 8'h11, 1'b1);
        push_byte(2, 8'h20, 1'b1);
        push_byte(2, 8'h21, 1'b1);
        run_queues("rr");

        push_byte(3, 8'h30, 1'b0);
        push_byte(3, 8'h31, 1'b0);
        push_byte(3, 8'h32, 1'b1);
        push_byte(0, 8'h01, 1'b1);
        push_byte(1, 8'h02, 1'b0);
        push_byte(1, 8'h03, 1'b1);
        run_queues("atomic");

        push_byte(3, 8'h40, 1'b1);
        push_byte(3, 8'h41, 1'b0);
        push_byte(3, 8'h42, 1'b1);
        run_queues("solo");

        for (int round = 0; round < 6; round++) begin
            for (int r = 0; r < NUM; r++) begin
                if ($urandom_range(0, 1) == 1) begin
                    int npk = $urandom_range(1, 3);
                    for (int p = 0; p < npk; p++) begin
                        int len = $urandom_range(1, 3);
                        for (int b = 0; b < len; b++) push_byte(r, 8'($urandom), b == len - 1);
                    end
                end
            end
            run_queues("rand");
        end

        // Gap timeout: one non-last byte, then the requester goes silent.
        do_reset();
        req_valid[2]      = 1'b1;
        req_data[23:16]   = 8'h3C;
        req_last[2]       = 1'b0;
        wait_ready(2, "gap");
        check_eq("gap_data", 32'(tx_data), 32'h3C);
        req_valid[2] = 1'b0;
        k = 0;
        while (!tx_busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        while (tx_busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("gap_frame_end", 32'(tx_busy), 32'd0);
        n = 0;
        while (!abort_pulse && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("gap_abort_cycle", 32'(n), 32'(GAP + 1));
        check_eq("gap_active_drop", 32'(grant_active), 32'd0);
        @(negedge clk);
        check_eq("gap_abort_width", 32'(abort_pulse), 32'd0);
        req_valid[1]    = 1'b1;
        req_data[15:8]  = 8'h77;
        req_last[1]     = 1'b1;
        wait_ready(1, "gap_next");
        check_eq("gap_next_gid", 32'(grant_id), 32'd1);
        check_eq("gap_next_data", 32'(tx_data), 32'h77);
        req_valid[1] = 1'b0;

        // Reset while the transmitter is mid-frame.
        do_reset();
        req_valid[0]   = 1'b1;
        req_data[7:0]  = 8'h5A;
        req_last[0]    = 1'b1;
        k = 0;
        while (!tx_busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("mid_busy", 32'(tx_busy), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_start", 32'(tx_start), 32'd0);
        check_eq("mid_rst_active", 32'(grant_active), 32'd0);
        req_data[7:0] = 8'h6B;
        @(negedge clk);
        rst  = 1'b0;
        viol = 0;
        k    = 0;
        while (tx_busy && k < 100) begin
            if (tx_start) viol++;
            @(negedge clk);
            k++;
        end
        check_eq("mid_no_start_busy", 32'(viol), 32'd0);
        wait_ready(0, "mid_after");
        check_eq("mid_after_data", 32'(tx_data), 32'h6B);
        req_valid[0] = 1'b0;
        wait_tx_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
